// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - runs one ALU command through the register bank and shares the bank port with a host
// The bank port is host-owned in IDLE; a round-robin flag settles command/host write conflicts there.
module alu_cmd_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opa,
  input  logic [7:0]  cmd_opb,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  input  logic        host_wr_en,
  input  logic [31:0] host_wr_addr,
  input  logic [31:0] host_wr_data,
  input  logic [31:0] host_rd_addr,
  output logic [31:0] host_rd_data,
  output logic        host_ready,
  output logic        busy,
  output logic        rb_write_en,
  output logic [31:0] rb_write_addr,
  output logic [31:0] rb_write_data,
  output logic [31:0] rb_read_addr,
  input  logic [31:0] rb_read_data
);

  localparam logic [31:0] OPA_ADDR = 32'h00;
  localparam logic [31:0] OPB_ADDR = 32'h04;
  localparam logic [31:0] OPC_ADDR = 32'h08;
  localparam logic [31:0] RES_ADDR = 32'h0C;

  localparam logic PRIO_CMD  = 1'b0;
  localparam logic PRIO_HOST = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_OP, S_WAIT, S_READ, S_RESP
  } state_t;

  state_t     state, state_next;
  logic       prio;
  logic [7:0] opa_q, opb_q;
  logic [2:0] op_q;
  logic       conflict;

  assign conflict     = cmd_valid & host_wr_en;
  assign rsp_valid    = (state == S_RESP);
  assign busy         = (state != S_IDLE);
  assign host_rd_data = rb_read_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      prio     <= PRIO_CMD;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_next;
      // the loser of a conflicted cycle owns the next one
      if (state == S_IDLE && conflict)
        prio <= ~prio;
      if (state == S_IDLE && cmd_valid && cmd_ready) begin
        opa_q <= cmd_opa;
        opb_q <= cmd_opb;
        op_q  <= cmd_op;
      end
      if (state == S_READ)
        rsp_data <= rb_read_data[7:0];
    end
  end

  always_comb begin
    state_next    = state;
    cmd_ready     = 1'b0;
    host_ready    = 1'b0;
    rb_write_en   = 1'b0;
    rb_write_addr = '0;
    rb_write_data = '0;
    rb_read_addr  = OPA_ADDR;
    case (state)
      S_IDLE: begin
        cmd_ready     = !conflict || (prio == PRIO_CMD);
        host_ready    = !conflict || (prio == PRIO_HOST);
        rb_write_en   = host_wr_en & host_ready;
        rb_write_addr = host_wr_addr;
        rb_write_data = host_wr_data;
        rb_read_addr  = host_rd_addr;
        if (cmd_valid && cmd_ready)
          state_next = S_WR_A;
      end
      S_WR_A: begin
        rb_write_en   = 1'b1;
        rb_write_addr = OPA_ADDR;
        rb_write_data = {24'b0, opa_q};
        state_next    = S_WR_B;
      end
      S_WR_B: begin
        rb_write_en   = 1'b1;
        rb_write_addr = OPB_ADDR;
        rb_write_data = {24'b0, opb_q};
        state_next    = S_WR_OP;
      end
      S_WR_OP: begin
        rb_write_en   = 1'b1;
        rb_write_addr = OPC_ADDR;
        rb_write_data = {29'b0, op_q};
        state_next    = S_WAIT;
      end
      S_WAIT: begin
        rb_read_addr = RES_ADDR;
        state_next   = S_READ;
      end
      S_READ: begin
        rb_read_addr = RES_ADDR;
        state_next   = S_RESP;
      end
      S_RESP: begin
        rb_read_addr = RES_ADDR;
        if (rsp_ready)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (reset) begin
      cmd_ready   = 1'b0;
      host_ready  = 1'b0;
      rb_write_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer with a register bank stub
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_opa = '0;
  logic [7:0]  cmd_opb = '0;
  logic [2:0]  cmd_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [7:0]  rsp_data;
  logic        host_wr_en = 1'b0;
  logic [31:0] host_wr_addr = '0;
  logic [31:0] host_wr_data = '0;
  logic [31:0] host_rd_addr = '0;
  logic [31:0] host_rd_data;
  logic        host_ready;
  logic        busy;
  logic        rb_write_en;
  logic [31:0] rb_write_addr;
  logic [31:0] rb_write_data;
  logic [31:0] rb_read_addr;
  logic [31:0] rb_read_data;

  logic [31:0] mem [16];
  logic [7:0]  res_val = 8'h00;
  int          w08_count = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data), .host_ready(host_ready),
    .busy(busy),
    .rb_write_en(rb_write_en), .rb_write_addr(rb_write_addr), .rb_write_data(rb_write_data),
    .rb_read_addr(rb_read_addr), .rb_read_data(rb_read_data)
  );

  // bank stub: register 3 returns the scripted ALU result
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (rb_write_en) begin
      mem[rb_write_addr[5:2]] <= rb_write_data;
      if (rb_write_addr == 32'h08) w08_count++;
    end
  end
  assign rb_read_data = (rb_read_addr == 32'h0C) ? {24'h0, res_val} : mem[rb_read_addr[5:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 30) begin tick(); n++; end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_idle_timeout: busy=%0b want 0", tag, busy); end
  endtask

  task automatic test_reset();
    tick(); tick();
    cmd_valid = 1'b1; host_wr_en = 1'b1; host_wr_addr = 32'h10;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
    checks++; if (host_ready !== 1'b0) begin failures++; $display("FAIL rst_host_ready: got %0b want 0", host_ready); end
    checks++; if (rb_write_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en: got %0b want 0", rb_write_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL rst_rsp_data: got %02h want 00", rsp_data); end
    cmd_valid = 1'b0; host_wr_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    res_val = 8'h5A; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_opa = 8'h12; cmd_opb = 8'h34; cmd_op = 3'b001;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL single_cmd_ready: got %0b want 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0; #1;
    checks++; if ({rb_write_en, rb_write_addr, rb_write_data} !== {1'b1, 32'h00, 32'h12}) begin failures++; $display("FAIL single_wr_a: en=%0b addr=%h data=%h want 1/00/12", rb_write_en, rb_write_addr, rb_write_data); end
    checks++; if ({busy, cmd_ready, host_ready} !== 3'b100) begin failures++; $display("FAIL single_busy_rdy: got %b want 100", {busy, cmd_ready, host_ready}); end
    tick();
    checks++; if ({rb_write_en, rb_write_addr, rb_write_data} !== {1'b1, 32'h04, 32'h34}) begin failures++; $display("FAIL single_wr_b: en=%0b addr=%h data=%h want 1/04/34", rb_write_en, rb_write_addr, rb_write_data); end
    tick();
    checks++; if ({rb_write_en, rb_write_addr, rb_write_data} !== {1'b1, 32'h08, 32'h01}) begin failures++; $display("FAIL single_wr_op: en=%0b addr=%h data=%h want 1/08/01", rb_write_en, rb_write_addr, rb_write_data); end
    tick();
    checks++; if ({rb_write_en, rsp_valid, rb_read_addr} !== {2'b00, 32'h0C}) begin failures++; $display("FAIL single_wait: en=%0b rv=%0b raddr=%h want 0/0/0c", rb_write_en, rsp_valid, rb_read_addr); end
    tick();
    checks++; if ({rsp_valid, rb_read_addr} !== {1'b0, 32'h0C}) begin failures++; $display("FAIL single_read: rv=%0b raddr=%h want 0/0c", rsp_valid, rb_read_addr); end
    tick();
    checks++; if ({rsp_valid, rsp_data} !== {1'b1, 8'h5A}) begin failures++; $display("FAIL single_rsp: rv=%0b data=%02h want 1/5a", rsp_valid, rsp_data); end
    tick();
    checks++; if ({busy, rsp_valid} !== 2'b00) begin failures++; $display("FAIL single_idle: busy=%0b rv=%0b want 0/0", busy, rsp_valid); end
  endtask

  task automatic test_host_read();
    host_rd_addr = 32'h04; #1;
    checks++; if (rb_read_addr !== 32'h04) begin failures++; $display("FAIL hrd_addr: got %h want 04", rb_read_addr); end
    checks++; if (host_rd_data !== 32'h34) begin failures++; $display("FAIL hrd_data: got %h want 34", host_rd_data); end
    checks++; if (host_ready !== 1'b1) begin failures++; $display("FAIL hrd_host_ready: got %0b want 1", host_ready); end
    host_rd_addr = 32'h00;
  endtask

  task automatic test_back_to_back();
    int acc[$];
    rsp_ready = 1'b1; res_val = 8'h11;
    cmd_valid = 1'b1; cmd_opa = 8'h01; cmd_opb = 8'h02; cmd_op = 3'b110;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (cmd_valid && cmd_ready) acc.push_back(i);
      tick();
    end
    cmd_valid = 1'b0;
    checks++; if (acc.size() !== 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", acc.size()); end
    if (acc.size() >= 2) begin
      checks++; if (acc[1] - acc[0] !== 7) begin failures++; $display("FAIL b2b_spacing: got %0d want 7", acc[1] - acc[0]); end
    end
    wait_idle("b2b");
  endtask

  task automatic test_backpressure();
    int n = 0;
    rsp_ready = 1'b0; res_val = 8'hA5;
    cmd_valid = 1'b1; cmd_opa = 8'h03; cmd_opb = 8'h04; cmd_op = 3'b010;
    tick();
    cmd_valid = 1'b0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    res_val = 8'h77;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if ({rsp_valid, rsp_data, busy, host_ready} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin failures++; $display("FAIL bp_hold_%0d: rv=%0b data=%02h busy=%0b hr=%0b want 1/a5/1/0", i, rsp_valid, rsp_data, busy, host_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++; if ({busy, rsp_valid} !== 2'b00) begin failures++; $display("FAIL bp_release: busy=%0b rv=%0b want 0/0", busy, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    w08_count = 0;
    cmd_valid = 1'b1; cmd_opa = 8'h21; cmd_opb = 8'h43; cmd_op = 3'b011;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++; if ({rb_write_en, rb_write_addr} !== {1'b1, 32'h04}) begin failures++; $display("FAIL rmid_in_wr_b: en=%0b addr=%h want 1/04", rb_write_en, rb_write_addr); end
    reset = 1'b1; #1;
    checks++; if (rb_write_en !== 1'b0) begin failures++; $display("FAIL rmid_wr_en: got %0b want 0", rb_write_en); end
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if ({busy, rsp_valid} !== 2'b00) begin failures++; $display("FAIL rmid_after: busy=%0b rv=%0b want 0/0", busy, rsp_valid); end
    checks++; if (w08_count !== 0) begin failures++; $display("FAIL rmid_no_op_write: got %0d writes want 0", w08_count); end
  endtask

  task automatic test_conflict();
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_opa = 8'h05; cmd_opb = 8'h06; cmd_op = 3'b000;
    host_wr_en = 1'b1; host_wr_addr = 32'h10; host_wr_data = 32'hDEADBEEF;
    rsp_ready = 1'b1;
    tick();
    reset = 1'b0; #1;
    checks++; if ({cmd_ready, host_ready, rb_write_en} !== 3'b100) begin failures++; $display("FAIL cf_grant: cr/hr/we=%b want 100", {cmd_ready, host_ready, rb_write_en}); end
    tick();
    cmd_valid = 1'b0; #1;
    checks++; if (host_ready !== 1'b0) begin failures++; $display("FAIL cf_host_blocked: got %0b want 0", host_ready); end
    wait_idle("cf");
    checks++; if ({host_ready, rb_write_en, rb_write_addr, rb_write_data} !== {2'b11, 32'h10, 32'hDEADBEEF}) begin failures++; $display("FAIL cf_host_write: hr=%0b we=%0b addr=%h data=%h want 1/1/10/deadbeef", host_ready, rb_write_en, rb_write_addr, rb_write_data); end
    tick();
    host_wr_en = 1'b0; #1;
    checks++; if (mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL cf_bank: got %h want deadbeef", mem[4]); end
  endtask

  task automatic test_alternation();
    int host_grants = 0;
    int n = 0;
    cmd_valid = 1'b1; cmd_opa = 8'h07; cmd_opb = 8'h08; cmd_op = 3'b100;
    host_wr_en = 1'b1; host_wr_addr = 32'h14; host_wr_data = 32'h0000_0001;
    #1;
    while (!cmd_ready && n < 10) begin
      if (host_ready) host_grants++;
      tick();
      host_wr_data = host_wr_data + 1;
      n++;
    end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL alt_cmd_ready: got %0b want 1", cmd_ready); end
    checks++; if (host_grants !== 1) begin failures++; $display("FAIL alt_host_grants: got %0d want 1", host_grants); end
    checks++; if (host_ready !== 1'b0) begin failures++; $display("FAIL alt_host_loser: got %0b want 0", host_ready); end
    tick();
    cmd_valid = 1'b0; host_wr_en = 1'b0;
    wait_idle("alt");
  endtask

  initial begin
    test_reset();
    test_single();
    test_host_read();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_conflict();
    test_alternation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Sequences one ALU operation per command through the 16-entry register bank. It writes operand A, operand B and the opcode into bank registers 0/1/2, waits for the bank to register the ALU result into register 3, then reads it back and returns it on a valid/ready response port. It also owns the bank's single write/read port and arbitrates it against a host (bus-side) pass-through port, so the bus slave and the command source share the bank without collisions.

## Interface
- OPA_ADDR, 32'h00, bank byte address of operand A (register 0)
- OPB_ADDR, 32'h04, bank byte address of operand B (register 1)
- OPC_ADDR, 32'h08, bank byte address of the opcode register (register 2)
- RES_ADDR, 32'h0C, bank byte address of the result register (register 3, read-only)
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_opa  in  8  operand A
- cmd_opb  in  8  operand B
- cmd_op  in  3  opcode
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed when rsp_valid & rsp_ready
- rsp_data  out  8  result byte
- host_wr_en  in  1  host write request
- host_wr_addr  in  32  host write address
- host_wr_data  in  32  host write data
- host_rd_addr  in  32  host read address
- host_rd_data  out  32  host read data (= rb_read_data)
- host_ready  out  1  host write performed this cycle when host_wr_en & host_ready; host reads are valid only when high
- busy  out  1  high in every state except IDLE
- rb_write_en  out  1  to bank write_en
- rb_write_addr  out  32  to bank write_addr
- rb_write_data  out  32  to bank write_data
- rb_read_addr  out  32  to bank read_addr
- rb_read_data  in  32  from bank read_data (combinational in the bank)

## Operation
- States: IDLE, WR_A, WR_B, WR_OP, WAIT, READ, RESP.
- IDLE: bank port is driven from host (rb_write_* = host_wr_*, rb_write_en = host_wr_en & host_ready, rb_read_addr = host_rd_addr).
- Arbitration in IDLE is done by a one-bit round-robin flag prio (reset = CMD):
  - No conflict: cmd_ready = cmd_valid-independent 1, host_ready = 1.
  - Conflict (cmd_valid & host_wr_en): grant goes to the prio owner only; the loser's ready is 0. After a grant under conflict, prio flips to the loser.
- A host read alone never blocks a command. If a command is accepted, host_ready drops from the next cycle.
- Command accept latches opa/opb/op → WR_A.
- WR_A: write {24'b0, opa} to OPA_ADDR → WR_B.
- WR_B: write {24'b0, opb} to OPB_ADDR → WR_OP.
- WR_OP: write {29'b0, op} to OPC_ADDR → WAIT.
- WAIT: no write; the bank registers the result → READ.
- READ: rb_read_addr = RES_ADDR; rsp_data <= rb_read_data[7:0] → RESP.
- RESP: rsp_valid = 1 and rsp_data stable until rsp_ready; on handshake → IDLE.
- In all non-IDLE states: host_ready = 0, cmd_ready = 0, and rb_write_en is driven only by the sequencer. rb_read_addr = RES_ADDR in WAIT, READ and RESP, and = OPA_ADDR in WR_A, WR_B and WR_OP.
- Opcodes 4–7 (memory ops) are passed through unchanged. Their bank side effects are the caller's responsibility; the sequencer still returns register 3.

## Timing
- Reset values: state IDLE, prio CMD, rsp_valid 0, rsp_data 0, busy 0. While reset is high, cmd_ready, host_ready and rb_write_en are forced to 0.
- Command accepted at edge 0: bank writes occur at edges 1, 2 and 3; WAIT ends at edge 4; the result is captured at edge 5; rsp_valid is high from edge 5.
- Minimum command-to-command spacing is 7 cycles when rsp_ready is tied high (the response handshakes in the RESP cycle, returning to IDLE).
- Reset asserted mid-sequence aborts immediately: no further bank writes, rsp_valid is 0, and any latched command is discarded.
- rsp_ready held low keeps the block in RESP indefinitely, with the host blocked.
- Host write during a non-IDLE state is not performed; the host must hold host_wr_en until host_ready.

## Test plan
- Single command: opa=0x12, opb=0x34, op=3'b001, with the bank stub returning 0x5A at RES_ADDR and rsp_ready=1 → writes 0x12@0x00, 0x34@0x04, 0x1@0x08 on cycles 1–3; rsp_valid on cycle 5 with rsp_data=0x5A; back in IDLE on cycle 6.
- Conflict: cmd_valid and host_wr_en (0xDEADBEEF@0x10) both high from reset release → command granted first and host_ready=0; after the response, the host write appears on rb_write_* with rb_write_en=1.
- Alternation: the host writes back-to-back while a command stays pending → the host is granted at most once before cmd_ready=1.
- Backpressure: rsp_ready=0 for 10 cycles → rsp_valid stays high, rsp_data is stable, busy=1, host_ready=0; releasing rsp_ready for one cycle returns to IDLE.
- Reset mid-operation: assert reset in WR_B → rb_write_en=0 immediately; after release, state IDLE, rsp_valid=0, and no write to 0x08 occurs.
- Host read in IDLE: host_rd_addr=0x04 → rb_read_addr=0x04 and host_rd_data mirrors rb_read_data in the same cycle.
